// File: rtl/cat_cmd_pkg.sv
// Shared command bytes and controller state encoding for the cat command transmitter.
package cat_cmd_pkg;

    localparam logic [7:0] CMD_SHOW_BASE = 8'h41;
    localparam logic [7:0] CMD_HIDE_BASE = 8'h61;
    localparam logic [7:0] CMD_CLEAR     = 8'h60;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOAD,
        WAIT_TX,
        FINISH
    } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: LSB first, every bit held BIT_TICKS cycles, line idles high.
module uart_tx_byte #(
    parameter int unsigned BIT_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       byte_done_c
);

    localparam int unsigned TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    logic          active_q, active_d;
    logic [8:0]    frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          tx_q, tx_d;
    logic          last_tick_c;

    assign last_tick_c = (tick_q == TW'(BIT_TICKS - 1));
    // Fires in the final cycle of the stop bit so the next byte can follow closely.
    assign byte_done_c = active_q && last_tick_c && (bit_q == 4'd9);
    assign tx_o        = tx_q;

    always_comb begin
        active_d = active_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        tick_d   = tick_q;
        tx_d     = tx_q;
        if (!active_q) begin
            if (start_i) begin
                active_d = 1'b1;
                frame_d  = {1'b1, data_i};
                bit_d    = 4'd0;
                tick_d   = '0;
                tx_d     = 1'b0;
            end
        end else if (last_tick_c) begin
            tick_d = '0;
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = frame_q[0];
                frame_d = {1'b1, frame_q[8:1]};
            end
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            frame_q  <= '1;
            bit_q    <= '0;
            tick_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            frame_q  <= frame_d;
            bit_q    <= bit_d;
            tick_q   <= tick_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/cat_cmd_tx.sv
// Walks target vs. shadow bit by bit and sends show/hide/clear commands to the peer.
// Define CAT_CMD_TX_RESYNC_EN to prefix the first send after reset with a clear-all byte.
module cat_cmd_tx
    import cat_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 103_340_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] target,
    input  logic       send,
    input  logic       clear_all,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] shadow
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD;
`ifdef CAT_CMD_TX_RESYNC_EN
    localparam logic RESYNC_RST = 1'b1;
`else
    localparam logic RESYNC_RST = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] shadow_q, shadow_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       armed_q, armed_d;
    logic       clr_q, clr_d;
    logic       diff_q, diff_d;
    logic       resync_q, resync_d;
    logic       start_c;
    logic       byte_done_c;
    logic [7:0] cmd_c;

    assign cmd_c = clr_q ? CMD_CLEAR
                 : (tgt_q[idx_q] ? CMD_SHOW_BASE + 8'(idx_q) : CMD_HIDE_BASE + 8'(idx_q));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        armed_d  = 1'b1;
        clr_d    = clr_q;
        diff_d   = diff_q;
        resync_d = resync_q;
        start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                // armed_q keeps the first cycle after reset release deaf to requests.
                if (armed_q && (send || clear_all)) begin
                    busy_d = 1'b1;
                    idx_d  = 3'd0;
                    diff_d = send;
                    if (send) tgt_d = target;
                    if (clear_all || (send && resync_q)) begin
                        clr_d   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (tgt_q[idx_q] != shadow_q[idx_q]) state_d = LOAD;
                else if (idx_q == 3'd7)             state_d = FINISH;
                else                                 idx_d   = idx_q + 3'd1;
            end
            LOAD: begin
                start_c = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (byte_done_c) begin
                    if (clr_q) begin
                        shadow_d = 8'h00;
                        clr_d    = 1'b0;
                        resync_d = 1'b0;
                        idx_d    = 3'd0;
                        state_d  = diff_q ? SCAN : FINISH;
                    end else begin
                        shadow_d[idx_q] = tgt_q[idx_q];
                        if (idx_q == 3'd7) begin
                            state_d = FINISH;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = SCAN;
                        end
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tgt_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
            clr_q    <= 1'b0;
            diff_q   <= 1'b0;
            resync_q <= RESYNC_RST;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tgt_q    <= tgt_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            armed_q  <= armed_d;
            clr_q    <= clr_d;
            diff_q   <= diff_d;
            resync_q <= resync_d;
        end
    end

    uart_tx_byte #(
        .BIT_TICKS(BIT_TICKS)
    ) u_uart (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (start_c),
        .data_i     (cmd_c),
        .tx_o       (tx),
        .byte_done_c(byte_done_c)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign shadow = shadow_q;

endmodule

// File: tb/tb_cat_cmd_tx.sv
// Scoreboard bench for cat_cmd_tx at BIT_TICKS=16; a line monitor decodes frames and pops expectations.
module tb_cat_cmd_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] target;
    logic       send;
    logic       clear_all;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] shadow;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int d0;
    int cyc;
    logic [7:0] exp_q[$];
    logic [7:0] exp_sh_q[$];
    logic [7:0] m_shadow = 8'h00;
`ifdef CAT_CMD_TX_RESYNC_EN
    bit m_resync = 1'b1;
`else
    bit m_resync = 1'b0;
`endif

    cat_cmd_tx #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .target   (target),
        .send     (send),
        .clear_all(clear_all),
        .tx       (tx),
        .busy     (busy),
        .done     (done),
        .shadow   (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame monitor: samples every cycle of a frame so each bit's width is verified too.
    initial begin
        logic [9:0] bits;
        logic [7:0] eb;
        logic [7:0] es;
        bit ok;
        bit ab;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                ok = 1'b1;
                ab = 1'b0;
                bits = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < 16; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (reset_n !== 1'b1) ab = 1'b1;
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) ok = 1'b0;
                    end
                end
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'(bits[8:1]) | 32'h100, 32'h0);
                    end else begin
                        eb = exp_q.pop_front();
                        es = exp_sh_q.pop_front();
                        chk("byte", 32'(bits[8:1]), 32'(eb));
                        chk("start_stop", 32'({bits[9], bits[0]}), 32'h2);
                        chk("bit_width", 32'(ok), 32'h1);
                        @(negedge clk);
                        chk("shadow_after_byte", 32'(shadow), 32'(es));
                    end
                end
            end
        end
    end

    task automatic start_req(input logic [7:0] tgt, input bit s, input bit c);
        logic [7:0] sh;
        if (c || (s && m_resync)) begin
            exp_q.push_back(8'h60);
            exp_sh_q.push_back(8'h00);
            m_shadow = 8'h00;
            m_resync = 1'b0;
        end
        if (s) begin
            sh = m_shadow;
            for (int i = 0; i < 8; i++) begin
                if (tgt[i] != sh[i]) begin
                    sh[i] = tgt[i];
                    exp_q.push_back(tgt[i] ? 8'h41 + 8'(i) : 8'h61 + 8'(i));
                    exp_sh_q.push_back(sh);
                end
            end
            m_shadow = sh;
        end
        d0 = done_cnt;
        @(negedge clk);
        target    = tgt;
        send      = s;
        clear_all = c;
        @(negedge clk);
        send      = 1'b0;
        clear_all = 1'b0;
        chk("busy_rise", 32'(busy), 32'h1);
    endtask

    task automatic finish_req(input string tag);
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'h1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
        chk({tag, "_bytes_left"}, 32'(exp_q.size()), 32'h0);
        chk({tag, "_shadow"}, 32'(shadow), 32'(m_shadow));
        chk({tag, "_busy_low"}, 32'(busy), 32'h0);
    endtask

    initial begin
        reset_n   = 1'b0;
        target    = 8'h00;
        send      = 1'b0;
        clear_all = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_shadow", 32'(shadow), 32'h0);

        // Request held across the first post-reset edge must be ignored.
        reset_n = 1'b1;
        target  = 8'hFF;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("first_cycle_ignored", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("first_cycle_ignored_idle", 32'(busy), 32'h0);

        start_req(8'h05, 1'b1, 1'b0);
        finish_req("t05");

        start_req(8'h04, 1'b1, 1'b0);
        finish_req("t04");

        start_req(8'h04, 1'b1, 1'b0);
        finish_req("equal");
        chk("equal_done_le10", 32'(cyc <= 10), 32'h1);

        start_req(8'h03, 1'b1, 1'b0);
        finish_req("t03");

        start_req(8'h80, 1'b1, 1'b1);
        finish_req("send_clear");

        start_req(8'h00, 1'b0, 1'b1);
        finish_req("clear");

        // Requests while busy are dropped.
        start_req(8'h11, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        target    = 8'h00;
        send      = 1'b1;
        clear_all = 1'b1;
        @(negedge clk);
        send      = 1'b0;
        clear_all = 1'b0;
        chk("busy_held_on_drop", 32'(busy), 32'h1);
        finish_req("drop");

        // Reset in the middle of a data bit.
        start_req(8'h10, 1'b1, 1'b0);
        cyc = 0;
        while (tx !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_test_frame_started", 32'(tx), 32'h0);
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'h1);
        chk("midrst_shadow", 32'(shadow), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        exp_sh_q.delete();
        m_shadow = 8'h00;
`ifdef CAT_CMD_TX_RESYNC_EN
        m_resync = 1'b1;
`endif
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        chk("post_rst_tx_idle", 32'(tx), 32'h1);
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'h0);

        start_req(8'h01, 1'b1, 1'b0);
        finish_req("after_rst_1");
        start_req(8'h03, 1'b1, 1'b0);
        finish_req("after_rst_2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cat_cmd_tx.md
CAT_CMD_TX -- requirements
Module: cat_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 103_340_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600: serial bit rate; BIT_TICKS = CLK_FREQ/BAUD (integer truncation).
REQ-003 SHALL have port clk, input, 1: single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port target, input, 8: requested cat pattern; bit i = 1 means cat i shown (LED on at the peer).
REQ-006 SHALL have port send, input, 1: single-cycle request to transmit the commands that move the peer from shadow to target.
REQ-007 SHALL have port clear_all, input, 1: single-cycle request to transmit the clear-all command.
REQ-008 SHALL have port tx, output, 1: 8N1 UART line, idle high.
REQ-009 SHALL have port busy, output, 1: high from the cycle after an accepted request until the sequence completes.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-011 SHALL have port shadow, output, 8: pattern the peer holds after every completed byte.

Function
REQ-012 SHALL use command bytes: 0x41+i shows cat i; 0x61+i hides cat i; 0x60 hides all.
REQ-013 SHALL use FSM states IDLE, SCAN, LOAD, WAIT_TX, FINISH.
REQ-014 SHALL accept send/clear_all only in IDLE; requests while busy=1 SHALL be dropped with no side effect.
REQ-015 SHALL, on accepted send, latch target and enter SCAN; busy SHALL rise the next cycle.
REQ-016 SHALL in SCAN examine bit index 0..7 ascending, one index per cycle; a differing bit moves to LOAD, else index advances.
REQ-017 SHALL in LOAD hand the command byte (0x41+i if latched bit is 1, else 0x61+i) to the serializer, then enter WAIT_TX.
REQ-018 SHALL update shadow bit i only when that byte's stop bit completes, then resume SCAN at i+1.
REQ-019 SHALL enter FINISH after index 7 is examined; FINISH pulses done for 1 cycle, clears busy, returns to IDLE.
REQ-020 SHALL, when latched target equals shadow, emit no bytes and assert done within 10 cycles of send.
REQ-021 SHALL on accepted clear_all send 0x60, then set shadow to 0x00, then FINISH.
REQ-022 SHALL, when send and clear_all are asserted in the same IDLE cycle, send 0x60 first, then perform the diff sequence against shadow 0x00 using target latched in that cycle, with one done pulse at the end.
REQ-023 SHALL serialize LSB first: start bit 0, 8 data bits, stop bit 1, each held exactly BIT_TICKS cycles.
REQ-024 SHALL start a following start bit no later than 2 cycles after the previous stop bit ends.
REQ-025 SHALL keep tx = 1 whenever no frame is in progress.

Reset
REQ-026 SHALL, while reset_n = 0, force tx = 1, busy = 0, done = 0, shadow = 0x00, FSM = IDLE, serializer idle, bit counters 0, independent of clk.
REQ-027 SHALL abandon any partial frame on reset mid-transmission; no residual bit appears after release.
REQ-028 SHALL ignore send/clear_all in the first cycle after reset_n rises.

Configuration
REQ-029 SHALL honor macro CAT_CMD_TX_RESYNC_EN: when defined, the first accepted send after reset is preceded by an automatic 0x60 byte (shadow forced to 0x00) so the peer matches; when undefined, no automatic byte is sent and shadow = 0x00 is assumed to match the peer.

Structure
REQ-030 SHALL place command constants (CMD_SHOW_BASE 0x41, CMD_HIDE_BASE 0x61, CMD_CLEAR 0x60) and the FSM state encoding in shared package cat_cmd_pkg.
REQ-031 SHALL instantiate one sub-module, uart_tx_byte (start/data handshake in, tx and byte_done out, BIT_TICKS parameter).

Verification (CLK_FREQ=16, BAUD=1, so BIT_TICKS=16)
REQ-032 SHALL check: reset, target=0x05, send -> bytes 0x41 then 0x43, shadow 0x01 then 0x05, single done.
REQ-033 SHALL check: shadow=0x05, target=0x04, send -> one byte 0x61, shadow=0x04, each bit exactly 16 cycles.
REQ-034 SHALL check: target equals shadow, send -> tx stays 1, done within 10 cycles.
REQ-035 SHALL check: send and clear_all same cycle with target=0x80, shadow=0x03 -> bytes 0x60, 0x48; shadow 0x80.
REQ-036 SHALL check: send while busy -> dropped; reset_n low mid-data-bit -> tx=1 immediately, shadow=0x00, no further bytes.
REQ-037 SHALL check with CAT_CMD_TX_RESYNC_EN defined: first send target=0x01 -> bytes 0x60, 0x41; second send -> no 0x60.
